// File: rtl/mem_wb_load_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_load_stage
// Purpose  : MEM/WB pipeline register with an integrated load filter.
//            Captures the raw data-memory word, ALU result, immediate and
//            write-back controls. Extracts and extends the addressed
//            byte/half/word into o_filterL. Tracks a HALT drain for the
//            debug unit, counts retired register writes and keeps a
//            sticky misaligned-load flag.
// Ports    :
//   i_clk, i_reset       clock (rising edge), async active-low reset
//   i_step               advance enable; 0 holds every register
//   i_flush              latch a bubble on the next advance
//   i_mem_data           raw word read from data memory
//   i_alu_result         ALU result / memory address (low bits = lane)
//   i_extension          sign-extended immediate (LUI path)
//   i_load_size          00 byte, 01 half, 10/11 word
//   i_load_unsigned      1 = zero-extend byte/half
//   i_mem_to_reg, i_reg_write, i_lui, i_rd, i_halt   incoming controls
//   o_filterL, o_extension, o_alu_result            registered data
//   o_lui, o_mem_to_reg, o_reg_write, o_rd          registered controls
//   o_halted             stage has entered HALTED
//   o_misaligned         sticky misaligned-load flag
//   o_retired            count of retired register writes (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_load_stage #(
  parameter int BITS_SIZE     = 32,
  parameter int REG_ADDR_SIZE = 5,
  parameter int CNT_SIZE      = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_step,
  input  logic                     i_flush,
  input  logic [BITS_SIZE-1:0]     i_mem_data,
  input  logic [BITS_SIZE-1:0]     i_alu_result,
  input  logic [BITS_SIZE-1:0]     i_extension,
  input  logic [1:0]               i_load_size,
  input  logic                     i_load_unsigned,
  input  logic                     i_mem_to_reg,
  input  logic                     i_reg_write,
  input  logic                     i_lui,
  input  logic [REG_ADDR_SIZE-1:0] i_rd,
  input  logic                     i_halt,
  output logic [BITS_SIZE-1:0]     o_filterL,
  output logic [BITS_SIZE-1:0]     o_extension,
  output logic [BITS_SIZE-1:0]     o_alu_result,
  output logic                     o_lui,
  output logic                     o_mem_to_reg,
  output logic                     o_reg_write,
  output logic [REG_ADDR_SIZE-1:0] o_rd,
  output logic                     o_halted,
  output logic                     o_misaligned,
  output logic [CNT_SIZE-1:0]      o_retired
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [BITS_SIZE-1:0]     filter_q, filter_d;
  logic [BITS_SIZE-1:0]     ext_q, ext_d;
  logic [BITS_SIZE-1:0]     alu_q, alu_d;
  logic                     lui_q, lui_d;
  logic                     m2r_q, m2r_d;
  logic                     rw_q, rw_d;
  logic [REG_ADDR_SIZE-1:0] rd_q, rd_d;
  logic                     mis_q, mis_d;
  logic [CNT_SIZE-1:0]      cnt_q, cnt_d;

  // --------------------------------------------------------------------------
  // Load filter: pick the addressed lane (little-endian) and extend it.
  // --------------------------------------------------------------------------
  logic [1:0]           off;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [BITS_SIZE-1:0] filtered;
  logic                 misaligned;

  assign off = i_alu_result[1:0];

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = i_mem_data[7:0];
      2'd1: byte_sel = i_mem_data[15:8];
      2'd2: byte_sel = i_mem_data[23:16];
      default: byte_sel = i_mem_data[31:24];
    endcase
  end

  // Half lane uses only off[1]; an odd offset is caught as misaligned.
  assign half_sel = off[1] ? i_mem_data[31:16] : i_mem_data[15:0];

  always_comb begin
    filtered = i_mem_data;
    case (i_load_size)
      SZ_BYTE: filtered = {{(BITS_SIZE-8){byte_sel[7] & ~i_load_unsigned}}, byte_sel};
      SZ_HALF: filtered = {{(BITS_SIZE-16){half_sel[15] & ~i_load_unsigned}}, half_sel};
      default: filtered = i_mem_data;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (i_mem_to_reg) begin
      case (i_load_size)
        SZ_BYTE: misaligned = 1'b0;
        SZ_HALF: misaligned = off[0];
        default: misaligned = (off != 2'd0);
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Priority on an advance: flush > HALTED bubble > capture.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    filter_d = filter_q;
    ext_d    = ext_q;
    alu_d    = alu_q;
    lui_d    = lui_q;
    m2r_d    = m2r_q;
    rw_d     = rw_q;
    rd_d     = rd_q;
    mis_d    = mis_q;
    cnt_d    = cnt_q;

    if (i_step) begin
      if (i_flush || (state_q == ST_HALTED)) begin
        // Bubble: controls cleared, data loaded with zero, no state change.
        filter_d = '0;
        ext_d    = '0;
        alu_d    = '0;
        lui_d    = 1'b0;
        m2r_d    = 1'b0;
        rw_d     = 1'b0;
        rd_d     = '0;
      end else begin
        filter_d = filtered;
        ext_d    = i_extension;
        alu_d    = i_alu_result;
        lui_d    = i_lui;
        m2r_d    = i_mem_to_reg;
        rw_d     = i_reg_write & ~misaligned;
        rd_d     = i_rd;
        if (misaligned) begin
          mis_d = 1'b1;
        end
        if (i_halt) begin
          state_d = ST_HALTED;
        end
      end
      // Bubbles never write, so the counter freezes in HALTED naturally.
      if (rw_d) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_RUN;
      filter_q <= '0;
      ext_q    <= '0;
      alu_q    <= '0;
      lui_q    <= 1'b0;
      m2r_q    <= 1'b0;
      rw_q     <= 1'b0;
      rd_q     <= '0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      ext_q    <= ext_d;
      alu_q    <= alu_d;
      lui_q    <= lui_d;
      m2r_q    <= m2r_d;
      rw_q     <= rw_d;
      rd_q     <= rd_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_filterL    = filter_q;
  assign o_extension  = ext_q;
  assign o_alu_result = alu_q;
  assign o_lui        = lui_q;
  assign o_mem_to_reg = m2r_q;
  assign o_reg_write  = rw_q;
  assign o_rd         = rd_q;
  assign o_halted     = (state_q == ST_HALTED);
  assign o_misaligned = mis_q;
  assign o_retired    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_load_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_load_stage
// Purpose  : Directed self-checking bench for mem_wb_load_stage. Uses a
//            4-bit retired counter so the wrap can be reached quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_load_stage;

  logic        clk;
  logic        rst_n;
  logic        step, flush, lu, m2r, rw, lui, halt;
  logic [31:0] mem, alu, ext;
  logic [1:0]  lsz;
  logic [4:0]  rd;
  logic [31:0] o_filterL, o_extension, o_alu_result;
  logic        o_lui, o_mem_to_reg, o_reg_write, o_halted, o_misaligned;
  logic [4:0]  o_rd;
  logic [3:0]  o_retired;

  int checks = 0;
  int passes = 0;

  mem_wb_load_stage #(
    .BITS_SIZE(32), .REG_ADDR_SIZE(5), .CNT_SIZE(4)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_step(step), .i_flush(flush),
    .i_mem_data(mem), .i_alu_result(alu), .i_extension(ext),
    .i_load_size(lsz), .i_load_unsigned(lu), .i_mem_to_reg(m2r),
    .i_reg_write(rw), .i_lui(lui), .i_rd(rd), .i_halt(halt),
    .o_filterL(o_filterL), .o_extension(o_extension), .o_alu_result(o_alu_result),
    .o_lui(o_lui), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_rd(o_rd), .o_halted(o_halted), .o_misaligned(o_misaligned),
    .o_retired(o_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus setter (no checking here).
  task automatic drive(input logic s, input logic f, input logic [31:0] m,
                       input logic [31:0] a, input logic [31:0] e,
                       input logic [1:0] sz, input logic u, input logic mr,
                       input logic w, input logic l, input logic [4:0] d,
                       input logic h);
    step = s; flush = f; mem = m; alu = a; ext = e; lsz = sz; lu = u;
    m2r = mr; rw = w; lui = l; rd = d; halt = h;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    checks++;
    if ({o_filterL, o_extension, o_alu_result} !== 96'h0)
      $display("FAIL reset_data: got %h %h %h want 0", o_filterL, o_extension, o_alu_result);
    else passes++;
    checks++;
    if ({o_lui, o_mem_to_reg, o_reg_write, o_rd, o_halted, o_misaligned, o_retired} !== 14'h0)
      $display("FAIL reset_ctrl: got lui=%b m2r=%b rw=%b rd=%0d h=%b mis=%b cnt=%0d want all 0",
               o_lui, o_mem_to_reg, o_reg_write, o_rd, o_halted, o_misaligned, o_retired);
    else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte_loads();
    // LB off=3 from 0x80123456 -> lane 0x80, sign-extended.
    drive(1'b1, 1'b0, 32'h80123456, 32'h00001003, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0);
    tick();
    checks++;
    if (o_filterL !== 32'hFFFFFF80) $display("FAIL lb_signed: got %h want FFFFFF80", o_filterL);
    else passes++;
    checks++;
    if (o_reg_write !== 1'b1 || o_rd !== 5'd5 || o_retired !== 4'd1)
      $display("FAIL lb_ctrl: got rw=%b rd=%0d cnt=%0d want 1 5 1", o_reg_write, o_rd, o_retired);
    else passes++;
    // LBU same address -> zero-extend.
    lu = 1'b1;
    tick();
    checks++;
    if (o_filterL !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", o_filterL);
    else passes++;
  endtask

  task automatic test_half_loads();
    drive(1'b1, 1'b0, 32'hBEEF1234, 32'h00000002, 32'h0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0);
    tick();
    checks++;
    if (o_filterL !== 32'hFFFFBEEF) $display("FAIL lh_off2: got %h want FFFFBEEF", o_filterL);
    else passes++;
    // LHU off=0 of 0xBEEF8001 -> 0x8001 zero-extended.
    drive(1'b1, 1'b0, 32'hBEEF8001, 32'h00000000, 32'h0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0);
    tick();
    checks++;
    if (o_filterL !== 32'h00008001 || o_retired !== 4'd4)
      $display("FAIL lhu_off0: got %h cnt=%0d want 00008001 cnt=4", o_filterL, o_retired);
    else passes++;
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b0, 32'hBEEF1234, 32'h00000001, 32'h0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
    tick();
    checks++;
    if (o_misaligned !== 1'b1 || o_reg_write !== 1'b0 || o_retired !== 4'd4)
      $display("FAIL lh_misaligned: got mis=%b rw=%b cnt=%0d want 1 0 4",
               o_misaligned, o_reg_write, o_retired);
    else passes++;
    // Valid aligned LW afterwards: flag sticks, write retires.
    drive(1'b1, 1'b0, 32'hCAFEF00D, 32'h00000010, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0);
    tick();
    checks++;
    if (o_misaligned !== 1'b1 || o_reg_write !== 1'b1 || o_filterL !== 32'hCAFEF00D || o_retired !== 4'd5)
      $display("FAIL lw_after_mis: got mis=%b rw=%b data=%h cnt=%0d want 1 1 CAFEF00D 5",
               o_misaligned, o_reg_write, o_filterL, o_retired);
    else passes++;
  endtask

  task automatic test_hold_lui();
    drive(1'b0, 1'b0, 32'h0, 32'h00000040, 32'h12340000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0);
    tick(); tick(); tick();
    checks++;
    if (o_lui !== 1'b0 || o_extension !== 32'h0 || o_rd !== 5'd9 || o_alu_result !== 32'h10)
      $display("FAIL hold: got lui=%b ext=%h rd=%0d alu=%h want 0 0 9 10",
               o_lui, o_extension, o_rd, o_alu_result);
    else passes++;
    step = 1'b1;
    tick();
    checks++;
    if (o_lui !== 1'b1 || o_extension !== 32'h12340000 || o_rd !== 5'd10 || o_retired !== 4'd6)
      $display("FAIL lui_step: got lui=%b ext=%h rd=%0d cnt=%0d want 1 12340000 10 6",
               o_lui, o_extension, o_rd, o_retired);
    else passes++;
  endtask

  task automatic test_flush_halt();
    drive(1'b1, 1'b1, 32'h0, 32'h00000003, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 1'b1);
    tick();
    checks++;
    if (o_halted !== 1'b0 || o_reg_write !== 1'b0 || o_lui !== 1'b0 || o_mem_to_reg !== 1'b0 ||
        o_rd !== 5'd0 || o_retired !== 4'd6)
      $display("FAIL flush_halt: got h=%b rw=%b lui=%b m2r=%b rd=%0d cnt=%0d want 0 0 0 0 0 6",
               o_halted, o_reg_write, o_lui, o_mem_to_reg, o_rd, o_retired);
    else passes++;
  endtask

  task automatic test_counter_wrap();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (o_retired !== 4'hF) $display("FAIL cnt_max: got %0d want 15", o_retired);
    else passes++;
    tick();
    checks++;
    if (o_retired !== 4'h0) $display("FAIL cnt_wrap: got %0d want 0", o_retired);
    else passes++;
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b0, 32'h0, 32'h00000077, 32'h0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 1'b1);
    tick();
    checks++;
    if (o_halted !== 1'b1 || o_reg_write !== 1'b1 || o_rd !== 5'd12 || o_retired !== 4'd1)
      $display("FAIL halt_capture: got h=%b rw=%b rd=%0d cnt=%0d want 1 1 12 1",
               o_halted, o_reg_write, o_rd, o_retired);
    else passes++;
    halt = 1'b0;
    rd = 5'd13;
    tick(); tick();
    checks++;
    if (o_halted !== 1'b1 || o_reg_write !== 1'b0 || o_rd !== 5'd0 || o_retired !== 4'd1)
      $display("FAIL halted_drain: got h=%b rw=%b rd=%0d cnt=%0d want 1 0 0 1",
               o_halted, o_reg_write, o_rd, o_retired);
    else passes++;
  endtask

  task automatic test_async_reset();
    checks++;
    if (o_misaligned !== 1'b1 || o_halted !== 1'b1)
      $display("FAIL pre_reset_state: got mis=%b h=%b want 1 1", o_misaligned, o_halted);
    else passes++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_filterL, o_extension, o_alu_result, o_lui, o_mem_to_reg, o_reg_write, o_rd,
         o_halted, o_misaligned, o_retired} !== 110'h0)
      $display("FAIL async_reset: got h=%b mis=%b cnt=%0d alu=%h want all 0",
               o_halted, o_misaligned, o_retired, o_alu_result);
    else passes++;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_half_loads();
    test_misaligned();
    test_hold_lui();
    test_flush_halt();
    test_counter_wrap();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
